// File: rtl/alu_pkg.sv
// Shared funct codes, ALU Signal encodings and issue-FSM states for the ALU issue controller.
// Signal codes follow the ALU's own funct-style encoding.
package alu_pkg;

  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_ADDU = 6'd33;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_SUBU = 6'd35;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_SLT  = 6'd42;

  localparam logic [5:0] SIG_ADD = 6'b100000;
  localparam logic [5:0] SIG_SUB = 6'b100010;
  localparam logic [5:0] SIG_AND = 6'b100100;
  localparam logic [5:0] SIG_OR  = 6'b100101;
  localparam logic [5:0] SIG_SLT = 6'b101010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational R-type decode: instruction word to ALU Signal, illegal flag, signed-arith flag.
// Zero latency; no handshake.
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  signal,
  output logic        illegal,
  output logic        is_signed_arith
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_mid;

  assign opcode     = instr[31:26];
  assign funct      = instr[5:0];
  assign unused_mid = ^instr[25:6];

  always_comb begin
    signal          = 6'b000000;
    illegal         = 1'b1;
    is_signed_arith = 1'b0;
    if (opcode == 6'd0) begin
      illegal = 1'b0;
      case (funct)
        FN_ADD:  begin signal = SIG_ADD; is_signed_arith = 1'b1; end
        FN_ADDU: signal = SIG_ADD;
        FN_SUB:  begin signal = SIG_SUB; is_signed_arith = 1'b1; end
        FN_SUBU: signal = SIG_SUB;
        FN_AND:  signal = SIG_AND;
        FN_OR:   signal = SIG_OR;
        FN_SLT:  signal = SIG_SLT;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one R-type op at a time to the combinational ALU; legal ops 2-cycle, illegal 1-cycle latency.
// in_ready only in IDLE or on the DONE handshake cycle; result held until out_ready. ALU_OVF_DETECT_EN adds signed overflow.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_opA,
  input  logic [31:0]      in_opB,
  output logic [31:0]      alu_dataA,
  output logic [31:0]      alu_dataB,
  output logic [5:0]       alu_signal,
  input  logic [31:0]      alu_dataOut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_illegal,
  output logic             out_ovf,
  output logic [CNT_W-1:0] op_count
);

  state_t     state, state_nxt;
  logic [5:0] dec_sig;
  logic       dec_ill;
  logic       dec_sgn;
  logic       accept;
  logic       retire;
  logic       ovf_calc;

  alu_funct_decode u_dec (
    .instr           (in_instr),
    .signal          (dec_sig),
    .illegal         (dec_ill),
    .is_signed_arith (dec_sgn)
  );

  assign out_valid = (state == DONE);
  assign retire    = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid && in_ready;
    case (state)
      IDLE: if (accept) state_nxt = dec_ill ? DONE : EXEC;
      EXEC: state_nxt = DONE;
      DONE: begin
        if (accept)      state_nxt = dec_ill ? DONE : EXEC;
        else if (retire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ALU_OVF_DETECT_EN
  // Only funct 32/34 flag overflow; ADDU/SUBU share the Signal code but not this bit.
  logic sgn_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  sgn_q <= 1'b0;
    else if (accept && !dec_ill) sgn_q <= dec_sgn;
  end

  assign ovf_calc = sgn_q &&
                    ((alu_signal == SIG_SUB)
                       ? ((alu_dataA[31] != alu_dataB[31]) && (alu_dataOut[31] != alu_dataA[31]))
                       : ((alu_dataA[31] == alu_dataB[31]) && (alu_dataOut[31] != alu_dataA[31])));
`else
  logic unused_sgn;
  assign unused_sgn = dec_sgn;
  assign ovf_calc   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_dataA   <= 32'd0;
      alu_dataB   <= 32'd0;
      alu_signal  <= 6'b000000;
      out_result  <= 32'd0;
      out_illegal <= 1'b0;
      out_ovf     <= 1'b0;
      op_count    <= '0;
    end else begin
      // Illegal requests never touch the ALU operand registers.
      if (accept && !dec_ill) begin
        alu_dataA  <= in_opA;
        alu_dataB  <= in_opB;
        alu_signal <= dec_sig;
      end
      if (accept && dec_ill) begin
        out_result  <= 32'd0;
        out_illegal <= 1'b1;
        out_ovf     <= 1'b0;
      end else if (state == EXEC) begin
        out_result  <= alu_dataOut;
        out_illegal <= 1'b0;
        out_ovf     <= ovf_calc;
      end
      if (retire) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the alu_* port.
module tb_alu_issue_ctrl;

`ifdef ALU_OVF_DETECT_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_opA;
  logic [31:0] in_opB;
  logic [31:0] alu_dataA;
  logic [31:0] alu_dataB;
  logic [5:0]  alu_signal;
  logic [31:0] alu_dataOut;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_illegal;
  logic        out_ovf;
  logic [15:0] op_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_opA      (in_opA),
    .in_opB      (in_opB),
    .alu_dataA   (alu_dataA),
    .alu_dataB   (alu_dataB),
    .alu_signal  (alu_signal),
    .alu_dataOut (alu_dataOut),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_illegal (out_illegal),
    .out_ovf     (out_ovf),
    .op_count    (op_count)
  );

  // Stand-in for the combinational ALU
  always_comb begin
    alu_dataOut = 32'd0;
    case (alu_signal)
      6'b100000: alu_dataOut = alu_dataA + alu_dataB;
      6'b100010: alu_dataOut = alu_dataA - alu_dataB;
      6'b100100: alu_dataOut = alu_dataA & alu_dataB;
      6'b100101: alu_dataOut = alu_dataA | alu_dataB;
      6'b101010: alu_dataOut = {31'd0, $signed(alu_dataA) < $signed(alu_dataB)};
      default:   alu_dataOut = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns cycles from accept edge until out_valid is seen.
  task automatic send(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                      output int lat);
    in_instr = instr;
    in_opA   = a;
    in_opB   = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat;
  int cyc;

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    in_opA    = 32'd0;
    in_opB    = 32'd0;
    out_ready = 1'b1;
    #12;
    chk("rst_vld",  32'(out_valid), 32'd0);
    chk("rst_res",  out_result, 32'd0);
    chk("rst_cnt",  32'(op_count), 32'd0);
    chk("rst_sig",  32'(alu_signal), 32'd0);
    chk("rst_rdy",  32'(in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    send(32'h0000_0020, 32'd5, 32'd7, lat);
    chk("add_lat", 32'(lat), 32'd2);
    chk("add_sig", 32'(alu_signal), 32'h20);
    chk("add_res", out_result, 32'd12);
    chk("add_ill", 32'(out_illegal), 32'd0);
    @(posedge clk); #1;
    chk("add_cnt", 32'(op_count), 32'd1);
    chk("add_vld0", 32'(out_valid), 32'd0);

    send(32'h0000_002A, 32'hFFFF_FFFF, 32'd1, lat);
    chk("slt_sig", 32'(alu_signal), 32'h2A);
    chk("slt_res", out_result, 32'd1);
    @(posedge clk); #1;

    send(32'h0000_0022, 32'd3, 32'd5, lat);
    chk("sub_res", out_result, 32'hFFFF_FFFE);
    @(posedge clk); #1;

    send(32'h2000_0020, 32'hAAAA_AAAA, 32'h5555_5555, lat);
    chk("opc_lat", 32'(lat), 32'd1);
    chk("opc_res", out_result, 32'd0);
    chk("opc_ill", 32'(out_illegal), 32'd1);
    chk("opc_sig", 32'(alu_signal), 32'h22);
    chk("opc_a",   alu_dataA, 32'd3);
    chk("opc_b",   alu_dataB, 32'd5);
    @(posedge clk); #1;

    send(32'h0000_0027, 32'd9, 32'd9, lat);
    chk("f39_lat", 32'(lat), 32'd1);
    chk("f39_ill", 32'(out_illegal), 32'd1);
    chk("f39_a",   alu_dataA, 32'd3);
    @(posedge clk); #1;
    chk("ill_cnt", 32'(op_count), 32'd5);

    out_ready = 1'b0;
    send(32'h0000_0025, 32'h0000_00F0, 32'h0000_000F, lat);
    for (int i = 0; i < 5; i++) begin
      chk("stall_res", out_result, 32'h0000_00FF);
      chk("stall_rdy", 32'(in_ready), 32'd0);
      chk("stall_vld", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_instr  = 32'h0000_0020;
    in_opA    = 32'h10;
    in_opB    = 32'h20;
    in_valid  = 1'b1;
    #1;
    chk("b2b_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_vld0", 32'(out_valid), 32'd0);
    chk("b2b_cnt",  32'(op_count), 32'd6);
    chk("b2b_a",    alu_dataA, 32'h10);
    @(posedge clk); #1;
    chk("b2b_vld1", 32'(out_valid), 32'd1);
    chk("b2b_res",  out_result, 32'h30);
    @(posedge clk); #1;

    send(32'h0000_0020, 32'h7FFF_FFFF, 32'd1, lat);
    chk("ovf_add_res", out_result, 32'h8000_0000);
    chk("ovf_add",     32'(out_ovf), 32'(OVF_EN));
    @(posedge clk); #1;
    send(32'h0000_0021, 32'h7FFF_FFFF, 32'd1, lat);
    chk("ovf_addu_res", out_result, 32'h8000_0000);
    chk("ovf_addu",     32'(out_ovf), 32'd0);
    @(posedge clk); #1;
    send(32'h0000_0022, 32'h8000_0000, 32'd1, lat);
    chk("ovf_sub_res", out_result, 32'h7FFF_FFFF);
    chk("ovf_sub",     32'(out_ovf), 32'(OVF_EN));
    @(posedge clk); #1;
    chk("pre_rst_cnt", 32'(op_count), 32'd10);

    in_instr = 32'h0000_0020;
    in_opA   = 32'd1;
    in_opB   = 32'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    chk("mrst_vld", 32'(out_valid), 32'd0);
    chk("mrst_res", out_result, 32'd0);
    chk("mrst_cnt", 32'(op_count), 32'd0);
    chk("mrst_sig", 32'(alu_signal), 32'd0);
    chk("mrst_a",   alu_dataA, 32'd0);
    chk("mrst_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk); #1;
    chk("mrst_vld2", 32'(out_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    in_instr = 32'h2000_0000;
    in_valid = 1'b1;
    cyc = 0;
    while (op_count != 16'hFFFF && cyc < 70000) begin
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("wrap_cyc", 32'(cyc), 32'd65536);
    chk("cnt_max",  32'(op_count), 32'h0000_FFFF);
    chk("wrap_vld", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    chk("cnt_wrap", 32'(op_count), 32'd0);
    chk("wrap_idle", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
